// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    localparam logic [AW-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/Decoder_5to32.sv
// 5-bit register index to 32-bit one-hot row select.
module Decoder_5to32
    import rf_wb_pkg::*;
(
    input  logic [4:0]      addr,
    output logic [NREG-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_row
            assign onehot[gi] = (addr == 5'(gi));
        end
    endgenerate

endmodule

// File: rtl/wb_rr_arb.sv
// Combinational round-robin picker: first valid at or above ptr, with wrap.
module wb_rr_arb #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding the single register-file write port
// through one registered output stage; x0 writes are swallowed at the handshake.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 rf_hold,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [31:0]          rf_wsel,
    output logic [31:0]          busy_mask
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_reg;
    logic            out_valid_reg;
    logic [AW-1:0]   out_rd_reg;
    logic [XLEN-1:0] out_data_reg;

    logic [AW-1:0]   rd_arr   [NREQ];
    logic [XLEN-1:0] data_arr [NREQ];

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [PW-1:0]   rr_ptr_next;
    logic [31:0]     dec_wsel;
    logic [31:0]     dec_busy;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign rd_arr[gi]   = req_rd[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    wb_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Grants are masked while reset is asserted so no handshake can
    // complete against a stage that is being cleared.
    assign can_accept  = rst_n & (~out_valid_reg | ~rf_hold);
    assign req_ready   = grant & {NREQ{can_accept}};
    assign xfer        = grant_any & can_accept;
    assign sel_rd      = rd_arr[grant_idx];
    assign sel_data    = data_arr[grant_idx];
    assign rr_ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_rd_reg    <= '0;
            out_data_reg  <= '0;
        end else begin
            if (xfer) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (xfer && (sel_rd != AW'(rf_wb_pkg::X0))) begin
                out_valid_reg <= 1'b1;
                out_rd_reg    <= sel_rd;
                out_data_reg  <= sel_data;
            end else if (out_valid_reg && !rf_hold) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign rf_we    = out_valid_reg & ~rf_hold;
    assign rf_waddr = out_rd_reg;
    assign rf_wdata = out_data_reg;

    Decoder_5to32 u_dec_wsel (
        .addr   (out_rd_reg),
        .onehot (dec_wsel)
    );

    Decoder_5to32 u_dec_busy (
        .addr   (out_rd_reg),
        .onehot (dec_busy)
    );

    assign rf_wsel   = dec_wsel & {32{rf_we}};
    assign busy_mask = dec_busy & {32{out_valid_reg}};

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 rf_hold;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic [31:0]          rf_wsel;
    logic [31:0]          busy_mask;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t expq[$];
    int  checks = 0;
    int  passes = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .NREQ (NREQ),
        .XLEN (XLEN),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .rf_hold   (rf_hold),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_wsel   (rf_wsel),
        .busy_mask (busy_mask)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd,
                           input logic [XLEN-1:0] d);
        req_valid[i]            = v;
        req_rd[i*AW +: AW]      = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        expq.push_back(e);
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got x%0d <= 0x%08h, expected no write",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                $display("write x%0d <= 0x%08h (expected x%0d <= 0x%08h)",
                         rf_waddr, rf_wdata, e.rd, e.data);
                chk("wr_addr", 64'(rf_waddr), 64'(e.rd));
                chk("wr_data", 64'(rf_wdata), 64'(e.data));
                chk("wr_sel", 64'(rf_wsel), 64'(32'd1 << e.rd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rf_hold   = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;

        // T1: reset with random inputs, then first write
        repeat (3) begin
            tick();
            req_valid = NREQ'($urandom);
            req_rd    = (NREQ*AW)'($urandom);
            req_data  = {$urandom, $urandom, $urandom};
            rf_hold   = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_we", 64'(rf_we), 64'(0));
        chk("rst_waddr", 64'(rf_waddr), 64'(0));
        chk("rst_wdata", 64'(rf_wdata), 64'(0));
        chk("rst_wsel", 64'(rf_wsel), 64'(0));
        chk("rst_busy", 64'(busy_mask), 64'(0));

        tick();
        rst_n = 1'b1; rf_hold = 1'b0; req_valid = '0;
        set_req(0, 1'b1, 5'd5, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'(3'b001));
        expect_write(5'd5, 32'hA5A5_A5A5);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t1_we", 64'(rf_we), 64'(1));
        chk("t1_wsel", 64'(rf_wsel), 64'(32'h20));

        // T3: x0 discard from req1 (rr_ptr is 1)
        tick();
        set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t3_ready", 64'(req_ready), 64'(3'b010));
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t3_we", 64'(rf_we), 64'(0));
        chk("t3_wsel", 64'(rf_wsel), 64'(0));
        chk("t3_busy", 64'(busy_mask), 64'(0));

        // T6: collision on x3 with rr_ptr=2 -> req2 first, then req0
        tick();
        set_req(0, 1'b1, 5'd3, 32'd1);
        set_req(2, 1'b1, 5'd3, 32'd2);
        @(negedge clk);
        chk("t6_first", 64'(req_ready), 64'(3'b100));
        expect_write(5'd3, 32'd2);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t6_second", 64'(req_ready), 64'(3'b001));
        expect_write(5'd3, 32'd1);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);

        // Bring rr_ptr back to 0 via a single req2 write
        tick();
        set_req(2, 1'b1, 5'd9, 32'h99);
        @(negedge clk);
        chk("align_ready", 64'(req_ready), 64'(3'b100));
        expect_write(5'd9, 32'h99);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        @(negedge clk);

        // T2: all requesters valid continuously -> grants 0,1,2,0,1,2
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                int r;
                r = c / 3 + ((i < c % 3) ? 1 : 0);
                set_req(i, 1'b1, AW'(10 + 3*r + i), 32'hC0DE_0000 + 32'(3*r + i));
            end
            @(negedge clk);
            chk("t2_ready", 64'(req_ready), 64'(1 << (c % 3)));
            if (c > 0) chk("t2_we", 64'(rf_we), 64'(1));
            expect_write(AW'(10 + c), 32'hC0DE_0000 + 32'(c));
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t2_last_we", 64'(rf_we), 64'(1));

        // T4: hold with rd=7 in the stage
        tick();
        set_req(1, 1'b1, 5'd7, 32'h77);
        @(negedge clk);
        chk("t4_ready", 64'(req_ready), 64'(3'b010));
        expect_write(5'd7, 32'h77);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        set_req(0, 1'b1, 5'd8, 32'h88);
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("t4_hold_we", 64'(rf_we), 64'(0));
            chk("t4_hold_busy", 64'(busy_mask), 64'(32'h80));
            chk("t4_hold_ready", 64'(req_ready), 64'(0));
            chk("t4_hold_wsel", 64'(rf_wsel), 64'(0));
        end
        tick();
        rf_hold = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("t4_release_we", 64'(rf_we), 64'(1));
        tick();
        @(negedge clk);
        chk("t4_once", 64'(rf_we), 64'(0));

        // Hold with empty stage: one request still loads, written after release
        tick();
        rf_hold = 1'b1;
        set_req(0, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        chk("he_ready", 64'(req_ready), 64'(3'b001));
        expect_write(5'd4, 32'h44);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("he_we", 64'(rf_we), 64'(0));
        chk("he_busy", 64'(busy_mask), 64'(32'h10));
        tick();
        rf_hold = 1'b0;
        @(negedge clk);
        chk("he_release_we", 64'(rf_we), 64'(1));

        // T5: reset with stage full drops the pending write
        tick();
        set_req(2, 1'b1, 5'd6, 32'h66);
        @(negedge clk);
        chk("t5_ready", 64'(req_ready), 64'(3'b100));
        @(posedge clk);
        #1 set_req(2, 1'b0, 5'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_we", 64'(rf_we), 64'(0));
        chk("t5_busy", 64'(busy_mask), 64'(0));
        chk("t5_waddr", 64'(rf_waddr), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_no_write", 64'(rf_we), 64'(0));

        chk("queue_empty", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
